frac_clock_gen: RTL and testbench

Multi-channel, runtime-programmable fractional clock generator. Each channel uses an ACC_WIDTH-bit phase accumulator, giving an average output frequency of f_clk_src × inc / 2^ACC_WIDTH. Period jitter is at most one clk_src cycle, and there is no long-term drift. The block sits next to the system PLL and drives peripheral timing (PSG, timers, UART baud) as clock-enables, with optional square-wave outputs. Increments change glitch-free at period boundaries.

---
 rtl/frac_clock_gen.sv | 105 ++++++++++
 tb/tb_frac_clock_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_clock_gen.sv
// Multi-channel fractional clock generator: one phase accumulator per channel produces
// clock-enable pulses and a square wave. New settings are staged and applied at a period boundary.
module frac_clock_gen #(
  parameter int                   CHANNELS  = 4,
  parameter int                   ACC_WIDTH = 24,
  parameter logic [ACC_WIDTH-1:0] RESET_INC = '0,
  parameter int                   CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_src,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic                 cfg_en,
  input  logic [CHANNELS-1:0]  sync,
  output logic [CHANNELS-1:0]  ce,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  pending
);

  logic [ACC_WIDTH-1:0] acc_q   [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_d   [CHANNELS];
  logic [ACC_WIDTH-1:0] inc_q   [CHANNELS];
  logic [ACC_WIDTH-1:0] inc_d   [CHANNELS];
  logic [ACC_WIDTH-1:0] p_inc_q [CHANNELS];
  logic [ACC_WIDTH-1:0] p_inc_d [CHANNELS];
  logic [ACC_WIDTH:0]   sum     [CHANNELS];

  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] p_en_q, p_en_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic [CHANNELS-1:0] carry, apply, wr;

  // NOTE: every signal gets a default before any condition, so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      // Out-of-range channel numbers never match any index, so they are ignored.
      wr[i]    = cfg_we && (int'(cfg_ch) == i);
      carry[i] = en_q[i] && !sync[i] && sum[i][ACC_WIDTH];
      apply[i] = pend_q[i] && (!en_q[i] || (inc_q[i] == '0) || carry[i] || sync[i]);

      inc_d[i]   = inc_q[i];
      en_d[i]    = en_q[i];
      p_inc_d[i] = p_inc_q[i];
      p_en_d[i]  = p_en_q[i];
      pend_d[i]  = pend_q[i];
      ce_d[i]    = carry[i];
      acc_d[i]   = (sync[i] || !en_q[i]) ? '0 : sum[i][ACC_WIDTH-1:0];

      // The running period finishes with the old increment; the staged one starts next cycle.
      if (apply[i]) begin
        inc_d[i]  = p_inc_q[i];
        en_d[i]   = p_en_q[i];
        pend_d[i] = 1'b0;
        if (!p_en_q[i]) begin
          acc_d[i] = '0;
          ce_d[i]  = 1'b0;
        end
      end

      // A write in the apply cycle restages, so pending stays set.
      if (wr[i]) begin
        p_inc_d[i] = cfg_inc;
        p_en_d[i]  = cfg_en;
        pend_d[i]  = 1'b1;
      end
    end
  end

  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they take the async reset.
  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]   <= '0;
        inc_q[i]   <= RESET_INC;
        p_inc_q[i] <= '0;
      end
      en_q   <= '0;
      p_en_q <= '0;
      pend_q <= '0;
      ce_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      p_inc_q <= p_inc_d;
      en_q    <= en_d;
      p_en_q  <= p_en_d;
      pend_q  <= pend_d;
      ce_q    <= ce_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      clk_out[i] = en_q[i] & ~acc_q[i][ACC_WIDTH-1];
    end
  end

  assign ce      = ce_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_frac_clock_gen.sv
// Bench for frac_clock_gen: a 3-channel 4-bit instance against a scoreboarded reference model,
// plus a 1-channel 16-bit instance for long-run pulse counting.
module tb_frac_clock_gen;

  localparam int NA = 3;
  localparam int WA = 4;

  logic          clk_src = 1'b0;
  logic          reset;
  logic          cfg_we_a;
  logic [1:0]    cfg_ch_a;
  logic [WA-1:0] cfg_inc_a;
  logic          cfg_en_a;
  logic [NA-1:0] sync_a;
  logic [NA-1:0] ce_a, clk_out_a, pending_a;

  logic          reset_b;
  logic          cfg_we_b;
  logic [0:0]    cfg_ch_b;
  logic [15:0]   cfg_inc_b;
  logic          cfg_en_b;
  logic [0:0]    sync_b;
  logic [0:0]    ce_b, clk_out_b, pending_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk_src = ~clk_src;

  frac_clock_gen #(.CHANNELS(NA), .ACC_WIDTH(WA)) dut_a (
    .clk_src(clk_src), .reset(reset), .cfg_we(cfg_we_a), .cfg_ch(cfg_ch_a),
    .cfg_inc(cfg_inc_a), .cfg_en(cfg_en_a), .sync(sync_a),
    .ce(ce_a), .clk_out(clk_out_a), .pending(pending_a)
  );

  frac_clock_gen #(.CHANNELS(1), .ACC_WIDTH(16)) dut_b (
    .clk_src(clk_src), .reset(reset_b), .cfg_we(cfg_we_b), .cfg_ch(cfg_ch_b),
    .cfg_inc(cfg_inc_b), .cfg_en(cfg_en_b), .sync(sync_b),
    .ce(ce_b), .clk_out(clk_out_b), .pending(pending_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of dut_a and its scoreboard.
  int m_acc [NA], m_inc [NA], m_pinc [NA];
  bit m_en [NA], m_pen [NA], m_pend [NA], m_ce [NA];
  logic [3*NA-1:0] sb_q [$];

  function automatic void model_reset();
    for (int i = 0; i < NA; i++) begin
      m_acc[i] = 0; m_inc[i] = 0; m_pinc[i] = 0;
      m_en[i] = 0; m_pen[i] = 0; m_pend[i] = 0; m_ce[i] = 0;
    end
  endfunction

  function automatic void model_step();
    logic [NA-1:0] e_ce, e_clk, e_pend;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NA; i++) begin
        int sum;
        bit carry, do_apply;
        sum      = m_acc[i] + m_inc[i];
        carry    = m_en[i] && !sync_a[i] && (sum >= (1 << WA));
        do_apply = m_pend[i] && (!m_en[i] || m_inc[i] == 0 || carry || sync_a[i]);
        m_acc[i] = (m_en[i] && !sync_a[i]) ? sum % (1 << WA) : 0;
        m_ce[i]  = carry;
        if (do_apply) begin
          m_inc[i]  = m_pinc[i];
          m_en[i]   = m_pen[i];
          m_pend[i] = 0;
          if (!m_pen[i]) begin m_acc[i] = 0; m_ce[i] = 0; end
        end
        if (cfg_we_a && cfg_ch_a == i) begin
          m_pinc[i] = int'(cfg_inc_a); m_pen[i] = cfg_en_a; m_pend[i] = 1;
        end
      end
    end
    for (int i = 0; i < NA; i++) begin
      e_ce[i]   = m_ce[i];
      e_clk[i]  = m_en[i] && (m_acc[i] < (1 << (WA - 1)));
      e_pend[i] = m_pend[i];
    end
    sb_q.push_back({e_ce, e_clk, e_pend});
  endfunction

  task automatic tick();
    logic [3*NA-1:0] exp;
    model_step();
    @(posedge clk_src);
    #1;
    cyc++;
    exp = sb_q.pop_front();
    check("sb", {ce_a, clk_out_a, pending_a}, exp);
  endtask

  task automatic wait_ce(input int ch, input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ce_a[ch] && n < max_cyc);
    if (!ce_a[ch]) check("ce_timeout", ce_a[ch], 1);
  endtask

  task automatic write_a(input int ch, input int inc, input bit en);
    cfg_we_a = 1'b1; cfg_ch_a = 2'(ch); cfg_inc_a = WA'(inc); cfg_en_a = en;
  endtask

  task automatic run_a();
    int n, cnt, last_t;
    // Reset state
    #3;
    check("rst_ce", ce_a, 0);
    check("rst_clk", clk_out_a, 0);
    check("rst_pend", pending_a, 0);
    model_reset();
    tick();
    reset = 1'b0;

    // Idle channel write: pending in 1, clk high from 2, ce at 6/10/14
    write_a(0, 4, 1);
    tick();
    cfg_we_a = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) tick();
      check("t1_ce", ce_a[0], (k >= 6 && (k - 6) % 4 == 0));
      check("t1_clk", clk_out_a[0], (k >= 2 && (k - 2) % 4 < 2));
      if (k <= 2) check("t1_pend", pending_a[0], k == 1);
    end

    // inc=3: three pulses per 16 cycles, spacing 5 or 6
    write_a(1, 3, 1);
    tick();
    cfg_we_a = 1'b0;
    wait_ce(1, 40, n);
    last_t = cyc;
    for (int w = 0; w < 3; w++) begin
      cnt = 0;
      for (int j = 0; j < 16; j++) begin
        tick();
        if (ce_a[1]) begin
          cnt++;
          check("t2_gap", (cyc - last_t) inside {5, 6}, 1);
          last_t = cyc;
        end
      end
      check("t2_cnt", cnt, 3);
    end

    // Running write mid-period: old period completes, then spacing 2
    wait_ce(0, 8, n);
    tick();
    write_a(0, 8, 1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (k == 2) cfg_we_a = 1'b0;
      check("t3_ce", ce_a[0], (k == 4 || k == 6 || k == 8));
      if (k <= 4) check("t3_pend", pending_a[0], k < 4);
    end

    // Two staged writes: only the last (inc=6) takes effect
    write_a(2, 1, 1);
    tick();
    cfg_we_a = 1'b0;
    wait_ce(2, 40, n);
    tick();
    write_a(2, 2, 1);
    tick();
    write_a(2, 6, 1);
    tick();
    cfg_we_a = 1'b0;
    check("t4_pend", pending_a[2], 1);
    wait_ce(2, 20, n);
    check("t4_first", n, 13);
    check("t4_applied", pending_a[2], 0);
    wait_ce(2, 10, n);
    check("t4_gap1", n, 3);
    wait_ce(2, 10, n);
    check("t4_gap2", n, 3);

    // Disable write: at apply ce, clk_out drop to 0 and stay there
    write_a(2, 5, 0);
    tick();
    cfg_we_a = 1'b0;
    check("t4b_pend", pending_a[2], 1);
    tick();
    check("t4b_pend0", pending_a[2], 0);
    check("t4b_ce", ce_a[2], 0);
    check("t4b_clk", clk_out_a[2], 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4b_idle", {ce_a[2], clk_out_a[2]}, 0);
    end

    // sync on ch1 at a carry point while a write is pending
    wait_ce(1, 10, n);
    write_a(1, 4, 1);
    tick();
    cfg_we_a = 1'b0;
    check("t5_pend", pending_a[1], 1);
    for (int k = 0; k < 10; k++) begin
      if (m_acc[1] + m_inc[1] >= (1 << WA)) break;
      tick();
    end
    sync_a = 3'b010;
    tick();
    sync_a = '0;
    check("t5_ce", ce_a[1], 0);
    check("t5_pend0", pending_a[1], 0);
    wait_ce(1, 10, n);
    check("t5_period", n, 4);

    // Asynchronous reset with a write pending
    write_a(0, 1, 1);
    tick();
    cfg_we_a = 1'b0;
    check("t6_pend", pending_a[0], 1);
    #2 reset = 1'b1;
    #1;
    check("t6_ce", ce_a, 0);
    check("t6_clk", clk_out_a, 0);
    check("t6_pend0", pending_a, 0);
    model_reset();
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      cnt += $countones({ce_a, pending_a});
    end
    check("t6_quiet", cnt, 0);

    // Write to a nonexistent channel is ignored
    write_a(3, 4, 1);
    tick();
    cfg_we_a = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt += $countones({ce_a, pending_a, clk_out_a});
    end
    check("t6_badch", cnt, 0);

    write_a(0, 4, 1);
    tick();
    cfg_we_a = 1'b0;
    wait_ce(0, 20, n);
    check("t6_restart", n, 5);
  endtask

  task automatic run_b();
    int cnt;
    repeat (2) @(posedge clk_src);
    #1 reset_b = 1'b0;
    cfg_we_b = 1'b1; cfg_ch_b = 1'b1; cfg_inc_b = 16'd1877; cfg_en_b = 1'b1;
    @(posedge clk_src); #1;
    cfg_we_b = 1'b0;
    repeat (3) begin @(posedge clk_src); #1; end
    check("b_badch", {pending_b, clk_out_b, ce_b}, 0);
    cfg_we_b = 1'b1; cfg_ch_b = 1'b0;
    @(posedge clk_src); #1;
    cfg_we_b = 1'b0;
    check("b_pend", pending_b, 1);
    @(posedge clk_src); #1;
    check("b_clk", clk_out_b, 1);
    cnt = 0;
    for (int k = 0; k < 65536; k++) begin
      @(posedge clk_src); #1;
      if (ce_b[0]) cnt++;
    end
    check("b_cnt", cnt, 1877);
  endtask

  initial begin
    reset = 1'b1; reset_b = 1'b1;
    cfg_we_a = 1'b0; cfg_ch_a = '0; cfg_inc_a = '0; cfg_en_a = 1'b0; sync_a = '0;
    cfg_we_b = 1'b0; cfg_ch_b = '0; cfg_inc_b = '0; cfg_en_b = 1'b0; sync_b = '0;
    fork
      run_a();
      run_b();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
